// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction-fetch front end with a prefetch queue. Owns the fetch PC,
//   issues reads to a stalling instruction memory (one read in flight),
//   buffers up to DEPTH fetched words with their PCs and hands them to decode.
//   A redirect flushes the queue and discards any read still in flight.
//
// Handshakes:
//   imem: imem_rd is raised with a stable imem_addr and held until the cycle
//     imem_done is high; imem_data/imem_err are sampled in that same cycle.
//   decode: the head word transfers on a rising edge where out_valid and
//     out_ready are both high; out_valid does not depend on out_ready.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   redirect,
//   redirect_pc       load a new fetch PC and flush the queue
//   halt              stop issuing reads (sticky until reset)
//   imem_rd/addr      read request and address
//   imem_data/done/err read response
//   out_valid/ready   head-of-queue handshake
//   out_instr/pc/
//   out_pc_next/err   head fields (all from storage)
//   count             entries held
//   halted            halt latched and no read in flight
//   fsm_state         debug view of the fetch FSM (0 idle, 1 wait, 2 drain)
module fetch_queue #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 4,
    parameter int INCR     = 2,
    parameter int RESET_PC = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    input  logic                         halt,
    output logic                         imem_rd,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [DATA_W-1:0]            imem_data,
    input  logic                         imem_done,
    input  logic                         imem_err,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_instr,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [ADDR_W-1:0]            out_pc_next,
    output logic                         out_err,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         halted,
    output logic [1:0]                   fsm_state
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_P  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] INCR_C  = ADDR_W'(INCR);
    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   fetch_pc, fetch_pc_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic                halt_l, halt_n;
    logic [CNT_W-1:0]    count_n;
    logic [PTR_W-1:0]    head, tail;
    logic                push, pop;

    logic [DATA_W-1:0]   instr_mem [DEPTH];
    logic [ADDR_W-1:0]   pc_mem    [DEPTH];
    logic                err_mem   [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_P) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid   = (count != '0);
    assign out_instr   = instr_mem[head];
    assign out_pc      = pc_mem[head];
    assign out_err     = out_valid && err_mem[head];
    assign out_pc_next = pc_mem[head] + INCR_C;
    assign imem_rd     = (state != S_IDLE);
    assign imem_addr   = addr_q;
    assign halted      = halt_l && (state == S_IDLE);
    assign fsm_state   = state;

    // Redirect suppresses both queue operations in its cycle.
    assign push = (state == S_WAIT) && imem_done && !redirect;
    assign pop  = out_valid && out_ready && !redirect;

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        addr_n     = addr_q;
        halt_n     = halt_l | halt;
        count_n    = count;

        if (redirect) begin
            count_n = '0;
        end else if (push && !pop) begin
            count_n = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_n = count - CNT_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (!redirect && !halt_l && (count < DEPTH_C)) begin
                    state_n = S_WAIT;
                    addr_n  = fetch_pc;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    // A completing response is dropped; otherwise wait it out.
                    state_n = imem_done ? S_IDLE : S_DRAIN;
                end else if (imem_done) begin
                    fetch_pc_n = fetch_pc + INCR_C;
                    if (imem_err) halt_n = 1'b1;
                    if ((count_n < DEPTH_C) && !halt_l && !imem_err && !halt) begin
                        addr_n = fetch_pc + INCR_C;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (imem_done) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        if (redirect) fetch_pc_n = redirect_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            fetch_pc <= RST_PC;
            addr_q   <= RST_PC;
            halt_l   <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            addr_q   <= addr_n;
            halt_l   <= halt_n;
            count    <= count_n;
            if (redirect) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) tail <= ptr_inc(tail);
                if (pop)  head <= ptr_inc(head);
            end
        end
    end

    // Queue storage carries no reset; entries are only read while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail] <= imem_data;
            pc_mem[tail]    <= addr_q;
            err_mem[tail]   <= imem_err;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int INCR  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = '0;
    logic        imem_done = 1'b0;
    logic        imem_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_pc_next;
    logic        out_err;
    logic [2:0]  count;
    logic        halted;
    logic [1:0]  fsm_state;

    fetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .INCR(INCR), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_done(imem_done), .imem_err(imem_err), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_pc_next(out_pc_next), .out_err(out_err), .count(count),
        .halted(halted), .fsm_state(fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    // scoreboard / reference model
    typedef struct packed {
        logic [15:0] data;
        logic [15:0] pc;
        logic        err;
    } ent_t;

    ent_t        exp_q[$];
    logic [15:0] m_pc;
    logic [15:0] m_addr;
    bit          m_busy;
    bit          m_drain;
    bit          m_halt_l;
    logic [15:0] err_addr;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h1234;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc = '0; m_addr = '0;
        m_busy = 0; m_drain = 0; m_halt_l = 0;
    endtask

    task automatic model_step(input bit r, input logic [15:0] rpc, input bit h,
                              input bit rdy, input bit dn, input logic [15:0] d, input bit e);
        int  n0;
        bit  old_halt;
        bit  do_pop;
        n0       = exp_q.size();
        old_halt = m_halt_l;
        do_pop   = (n0 != 0) && rdy && !r;
        if (r) begin
            exp_q.delete();
            m_pc = rpc;
            if (m_busy && dn) begin
                m_busy = 0; m_drain = 0;
            end else if (m_busy) begin
                m_drain = 1;
            end
        end else begin
            if (do_pop) exp_q.delete(0);
            if (m_busy && dn) begin
                if (m_drain) begin
                    m_busy = 0; m_drain = 0;
                end else begin
                    exp_q.push_back(ent_t'{d, m_addr, e});
                    m_pc = m_pc + 16'(INCR);
                    if (e) m_halt_l = 1;
                    if (exp_q.size() < DEPTH && !old_halt && !e && !h) m_addr = m_pc;
                    else m_busy = 0;
                end
            end else if (!m_busy && !old_halt && n0 < DEPTH) begin
                m_busy = 1;
                m_addr = m_pc;
            end
        end
        if (h) m_halt_l = 1;
    endtask

    task automatic compare_all();
        check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check_eq("count", 32'(count), 32'(exp_q.size()));
        check_eq("imem_rd", 32'(imem_rd), 32'(m_busy));
        check_eq("halted", 32'(halted), 32'(m_halt_l && !m_busy));
        if (m_busy) check_eq("imem_addr", 32'(imem_addr), 32'(m_addr));
        if (exp_q.size() != 0) begin
            check_eq("out_instr", 32'(out_instr), 32'(exp_q[0].data));
            check_eq("out_pc", 32'(out_pc), 32'(exp_q[0].pc));
            check_eq("out_pc_next", 32'(out_pc_next), 32'(16'(exp_q[0].pc + 16'(INCR))));
            check_eq("out_err", 32'(out_err), 32'(exp_q[0].err));
        end
    endtask

    // driver: check state left by the last edge, then drive the next cycle
    task automatic cycle(input bit r, input logic [15:0] rpc, input bit h, input bit rdy, input bit dn);
        @(negedge clk);
        compare_all();
        redirect    = r;
        redirect_pc = rpc;
        halt        = h;
        out_ready   = rdy;
        imem_done   = dn && m_busy;
        imem_data   = word_at(m_addr);
        imem_err    = (m_addr == err_addr);
        model_step(r, rpc, h, rdy, imem_done, imem_data, imem_err);
    endtask

    // asynchronous reset asserted mid-cycle; released at a falling edge
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_rd", 32'(imem_rd), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_err", 32'(out_err), 32'd0);
        model_reset();
        err_addr = 16'h0001;
        @(negedge clk);
        rst = 1'b1;
        redirect = 0; halt = 0; out_ready = 0; imem_done = 0; imem_err = 0;
        model_step(0, '0, 0, 0, 0, '0, 0);
    endtask

    task automatic run_random(input int n, input int red_div, input int halt_div,
                              input int rdy_pct, input int dn_pct);
        bit r; bit h; bit rdy; bit dn; logic [15:0] rpc;
        for (int i = 0; i < n; i++) begin
            r   = ($urandom_range(0, red_div - 1) == 0);
            h   = (halt_div > 0) && ($urandom_range(0, halt_div - 1) == 0);
            rdy = ($urandom_range(0, 99) < rdy_pct);
            dn  = ($urandom_range(0, 99) < dn_pct);
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'({$urandom_range(0, 32767), 1'b0});
            cycle(r, rpc, h, rdy, dn);
        end
    endtask

    initial begin
        // streaming with 1-cycle memory
        do_reset();
        for (int i = 0; i < 10; i++) cycle(0, '0, 0, 1, 1);

        // fill with decode stalled, then a single pop
        do_reset();
        for (int i = 0; i < 12; i++) cycle(0, '0, 0, 0, 1);
        check_eq("full_count", 32'(count), 32'd4);
        check_eq("full_rd", 32'(imem_rd), 32'd0);
        cycle(0, '0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, '0, 0, 0, 1);
        check_eq("refill_count", 32'(count), 32'd4);

        // 3-cycle memory, redirect in second wait cycle
        do_reset();
        cycle(0, '0, 0, 1, 0);
        cycle(1, 16'h0040, 0, 1, 0);
        cycle(0, '0, 0, 1, 1);
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 1, 0);
        check_eq("redir_addr", 32'(imem_addr), 32'h0040);
        check_eq("redir_count", 32'(count), 32'd0);
        for (int i = 0; i < 6; i++) cycle(0, '0, 0, 1, 1);

        // redirect, done and pop in one cycle
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 1);
        cycle(1, 16'h0100, 0, 1, 1);
        cycle(0, '0, 0, 0, 0);
        check_eq("rdp_count", 32'(count), 32'd0);
        check_eq("rdp_valid", 32'(out_valid), 32'd0);
        cycle(0, '0, 0, 0, 0);
        check_eq("rdp_addr", 32'(imem_addr), 32'h0100);

        // halt during a read
        do_reset();
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 1);
        cycle(0, '0, 0, 0, 1);
        check_eq("halt_halted", 32'(halted), 32'd1);
        check_eq("halt_count", 32'(count), 32'd1);
        for (int i = 0; i < 5; i++) cycle(0, '0, 0, 1, 1);
        cycle(1, 16'h0200, 0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, '0, 0, 1, 1);

        // fetch error at 0x0008
        do_reset();
        err_addr = 16'h0008;
        for (int i = 0; i < 12; i++) cycle(0, '0, 0, 1, 1);
        check_eq("err_halted", 32'(halted), 32'd1);

        // PC wrap from 0xFFFE
        do_reset();
        cycle(1, 16'hFFFE, 0, 1, 0);
        cycle(0, '0, 0, 1, 1);
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 1, 1);
        cycle(0, '0, 0, 1, 0);
        check_eq("wrap_addr", 32'(imem_addr), 32'h0000);
        check_eq("wrap_pc", 32'(out_pc), 32'hFFFE);
        check_eq("wrap_pc_next", 32'(out_pc_next), 32'h0000);
        for (int i = 0; i < 4; i++) cycle(0, '0, 0, 1, 1);

        // randomized phases
        for (int p = 0; p < 6; p++) begin
            do_reset();
            err_addr = (p % 2 == 1) ? 16'({$urandom_range(0, 15), 1'b0}) : 16'h0001;
            run_random(250, 12, (p >= 4) ? 150 : 0, 30 + 12 * p, 40 + 10 * p);
        end

        // reset while reads are in flight
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 1);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(0, '0, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
